uart_tx_ser: RTL and testbench
==============================

UART_TX_SER -- requirements
Module: uart_tx_ser

Interface
REQ-001 The module SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter BAUD_DIV, default 434, clk cycles per serial bit (legal range 2..65535).
REQ-003 Parameter PARITY_EN, default 0; 1 = append one parity bit after the data bits.
REQ-004 Parameter PARITY_ODD, default 0; 1 = odd parity, 0 = even (ignored when PARITY_EN=0).
REQ-005 Parameter STOP_BITS, default 1; legal values 1 or 2.
REQ-006 clk  input  1  system clock (PLL output domain).
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 tx_en  input  1  1 = new frames may start; 0 = finish the current frame, then hold idle.
REQ-009 tx_fifo_dvalid  input  1  TX FIFO not empty; tx_rdata is valid (first-word-fall-through).
REQ-010 tx_rdata  input  8  head-of-FIFO byte.
REQ-011 tx_rden  output  1  one-cycle pop strobe to TX FIFO.
REQ-012 tx  output  1  serial line, registered, idle high.
REQ-013 tx_busy  output  1  high from frame load until the last stop-bit cycle, inclusive.
REQ-014 tx_done  output  1  one-cycle pulse in the last cycle of each stop period.

Function
REQ-015 The FSM SHALL use states IDLE, START, DATA, PARITY, STOP.
REQ-016 In IDLE, when tx_en=1 and tx_fifo_dvalid=1: assert tx_rden for that cycle, latch tx_rdata into the shift register, enter START next cycle.
REQ-017 tx_rden SHALL never be asserted while tx_fifo_dvalid=0 and SHALL never be high two consecutive cycles.
REQ-018 Every bit period SHALL last exactly BAUD_DIV cycles; the baud counter SHALL reload to BAUD_DIV-1 at every bit boundary and count down to 0.
REQ-019 START drives tx=0; DATA drives 8 bits LSB first; PARITY drives XOR(data) XOR PARITY_ODD; STOP drives tx=1 for STOP_BITS bit periods.
REQ-020 The bit index SHALL run 0..7; after bit 7, go to PARITY if PARITY_EN=1, else STOP.
REQ-021 Frame length SHALL be (1+8+PARITY_EN+STOP_BITS)*BAUD_DIV cycles.
REQ-022 In the last STOP cycle, if tx_en=1 and tx_fifo_dvalid=1, the module SHALL pop and latch the next byte in that cycle and enter START next cycle (zero idle gap); otherwise it SHALL enter IDLE.
REQ-023 tx_en deassertion mid-frame SHALL NOT truncate the frame.
REQ-024 tx_rdata changes while not popping SHALL NOT affect the frame in progress.
REQ-025 tx SHALL be driven from a flop; the line value for a state appears in the first cycle of that state.

Reset
REQ-026 On rst=1 at a clk edge: state=IDLE, tx=1, tx_rden=0, tx_busy=0, tx_done=0, counters=0.
REQ-027 Reset mid-frame SHALL abort the frame; tx=1 in the cycle after reset is sampled; no pop SHALL occur while rst=1.

Structure
REQ-028 The shared package uart_pkg SHALL hold the FSM state encoding, the default BAUD_DIV, and the data-bit count (8).
REQ-029 The baud counter SHALL be one sub-module, uart_baud_gen (load, count-down, tick-at-zero outputs); everything else SHALL be in uart_tx_ser.

Verification (BAUD_DIV=4 unless stated)
REQ-030 Single byte 0x55, PARITY_EN=0 -> one tx_rden pulse; tx = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; tx_done after 40 cycles.
REQ-031 FIFO holds 0xA3 then 0x0F -> two pops exactly 40 cycles apart; no idle cycle between the frames; tx_busy stays high throughout.
REQ-032 PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1; PARITY_ODD=1 -> parity bit 0; frame 44 cycles.
REQ-033 STOP_BITS=2, byte 0xFF -> stop high 8 cycles; tx_done in the last of those 8 cycles; frame 44 cycles.
REQ-034 tx_en dropped during bit 3 with FIFO non-empty -> current frame completes, no further tx_rden, tx stays 1, tx_busy=0.
REQ-035 rst asserted during DATA bit 5 -> tx=1 next cycle; no pop; after release with dvalid=1, a new frame starts cleanly with a 4-cycle start bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, data width
// and default baud divisor.
package uart_pkg;

  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned BIT_IDX_W        = $clog2(DATA_BITS);
  localparam int unsigned BAUD_DIV_DEFAULT = 434;
  localparam int unsigned BAUD_CNT_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Parity bit for a data word; odd=1 inverts the even-parity result.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: reloads to BAUD_DIV-1 on load, counts down, holds at 0.
// tick_c marks the final cycle of the current bit period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  output logic [BAUD_CNT_W-1:0] count,
  output logic                  tick_c
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= BAUD_CNT_W'(BAUD_DIV - 1);
    end else if (count != '0) begin
      count <= count - BAUD_CNT_W'(1);
    end
  end

  assign tick_c = (count == '0);

endmodule

// File: rtl/uart_tx_ser.sv
// UART transmit serializer: pops bytes from a first-word-fall-through FIFO and
// shifts out start, 8 data bits LSB first, optional parity and 1 or 2 stop bits.
module uart_tx_ser
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = BAUD_DIV_DEFAULT,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_en,
  input  logic                 tx_fifo_dvalid,
  input  logic [DATA_BITS-1:0] tx_rdata,
  output logic                 tx_rden,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  tx_state_e              state_q, state_next;
  logic [DATA_BITS-1:0]   data_q, data_next;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_next;
  logic                   stop_idx_q, stop_idx_next;
  logic                   tx_q, busy_q, done_q;
  logic                   pop_c, tx_line_c, baud_load_c, tick_c;
  logic [BAUD_CNT_W-1:0]  baud_count;

  uart_baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_gen (
    .clk    (clk),
    .rst    (rst),
    .load   (baud_load_c),
    .count  (baud_count),
    .tick_c (tick_c)
  );

  // Counter idles at 0, so tick_c is also high in IDLE and covers the first load.
  assign baud_load_c = tick_c && (state_next != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_next;
      data_q     <= data_next;
      bit_idx_q  <= bit_idx_next;
      stop_idx_q <= stop_idx_next;
      tx_q       <= tx_line_c;
      busy_q     <= (state_next != ST_IDLE);
      // Raised one cycle early so the flop is high in the final stop cycle.
      done_q     <= (state_q == ST_STOP) && (baud_count == BAUD_CNT_W'(1)) &&
                    (stop_idx_q == STOP_LAST);
    end
  end

  always_comb begin
    state_next    = state_q;
    data_next     = data_q;
    bit_idx_next  = bit_idx_q;
    stop_idx_next = stop_idx_q;
    pop_c         = 1'b0;
    tx_line_c     = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (tx_en && tx_fifo_dvalid) begin
          pop_c      = 1'b1;
          data_next  = tx_rdata;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (tick_c) begin
          state_next   = ST_DATA;
          bit_idx_next = '0;
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
            state_next    = PARITY_EN ? ST_PARITY : ST_STOP;
            stop_idx_next = 1'b0;
          end else begin
            bit_idx_next = bit_idx_q + BIT_IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick_c) begin
          state_next    = ST_STOP;
          stop_idx_next = 1'b0;
        end
      end
      ST_STOP: begin
        if (tick_c) begin
          if (stop_idx_q != STOP_LAST) begin
            stop_idx_next = 1'b1;
          end else if (tx_en && tx_fifo_dvalid) begin
            pop_c      = 1'b1;
            data_next  = tx_rdata;
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (rst) begin
      pop_c = 1'b0;
    end

    // Line value of the upcoming state, so it appears in that state's first cycle.
    case (state_next)
      ST_START:  tx_line_c = 1'b0;
      ST_DATA:   tx_line_c = data_next[bit_idx_next];
      ST_PARITY: tx_line_c = parity_of(data_q, PARITY_ODD);
      default:   tx_line_c = 1'b1;
    endcase
  end

  // Pop must land in the same cycle the FIFO head is observed valid.
  assign tx_rden = pop_c;
  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_ser.sv
// Directed bench for uart_tx_ser: four instances cover no-parity, even/odd
// parity and two stop bits, all at BAUD_DIV=4.
module tb_uart_tx_ser;

  logic       clk;
  logic       rst;
  logic       dvalid;
  logic [7:0] rdata;
  logic [3:0] en;
  logic [3:0] tx_v, busy_v, done_v, rden_v;

  int n_assert = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_ser #(.BAUD_DIV(4)) u_base (
    .clk(clk), .rst(rst), .tx_en(en[0]), .tx_fifo_dvalid(dvalid), .tx_rdata(rdata),
    .tx_rden(rden_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));

  uart_tx_ser #(.BAUD_DIV(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
    .clk(clk), .rst(rst), .tx_en(en[1]), .tx_fifo_dvalid(dvalid), .tx_rdata(rdata),
    .tx_rden(rden_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));

  uart_tx_ser #(.BAUD_DIV(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .rst(rst), .tx_en(en[2]), .tx_fifo_dvalid(dvalid), .tx_rdata(rdata),
    .tx_rden(rden_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));

  uart_tx_ser #(.BAUD_DIV(4), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst(rst), .tx_en(en[3]), .tx_fifo_dvalid(dvalid), .tx_rdata(rdata),
    .tx_rden(rden_v[3]), .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line bits, index 0 first on the wire; unused upper bits stay 1.
  function automatic logic [11:0] make_bits(input logic [7:0] d, input logic pe,
                                            input logic p);
    logic [11:0] v;
    v      = '1;
    v[0]   = 1'b0;
    v[8:1] = d;
    if (pe) v[9] = p;
    return v;
  endfunction

  // Called on a negedge: present a byte, see the pop strobe, let it be taken.
  task automatic start_frame(input int which, input logic [7:0] b, input bit keep_valid,
                             input logic [7:0] next_b, input bit keep_en, input string tag);
    rdata     = b;
    dvalid    = 1'b1;
    en[which] = 1'b1;
    #1;
    chk({tag, "_pop"}, 32'(rden_v[which]), 32'd1);
    @(posedge clk);
    #1;
    dvalid    = keep_valid;
    rdata     = next_b;
    en[which] = keep_en;
    @(negedge clk);
  endtask

  // Checks every cycle of one frame; returns on the negedge of its last cycle.
  task automatic run_frame(input int which, input logic [11:0] bits, input int nbits,
                           input bit pop_last, input int drop_at, input string tag);
    int last;
    last = nbits * 4 - 1;
    for (int k = 0; k <= last; k++) begin
      chk({tag, "_tx"},   32'(tx_v[which]),   32'(bits[k / 4]));
      chk({tag, "_busy"}, 32'(busy_v[which]), 32'd1);
      chk({tag, "_done"}, 32'(done_v[which]), 32'(k == last));
      chk({tag, "_rden"}, 32'(rden_v[which]), 32'(pop_last && (k == last)));
      if (k == drop_at) en[which] = 1'b0;
      if (k != last) @(negedge clk);
    end
  endtask

  task automatic idle_check(input int which, input string tag);
    @(negedge clk);
    chk({tag, "_idle_tx"},   32'(tx_v[which]),   32'd1);
    chk({tag, "_idle_busy"}, 32'(busy_v[which]), 32'd0);
    chk({tag, "_idle_done"}, 32'(done_v[which]), 32'd0);
    chk({tag, "_idle_rden"}, 32'(rden_v[which]), 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    dvalid = 1'b1;
    en     = 4'hF;
    rdata  = 8'h12;

    // Reset with a ready FIFO: outputs idle and no pop strobe.
    repeat (3) @(negedge clk);
    chk("rst_tx",   32'(tx_v),   32'hF);
    chk("rst_busy", 32'(busy_v), 32'h0);
    chk("rst_done", 32'(done_v), 32'h0);
    chk("rst_rden", 32'(rden_v), 32'h0);
    rst    = 1'b0;
    dvalid = 1'b0;
    en     = 4'h0;
    @(negedge clk);
    chk("post_rst_tx", 32'(tx_v), 32'hF);

    // Single byte 0x55, no parity.
    start_frame(0, 8'h55, 1'b0, 8'h00, 1'b0, "b55");
    run_frame(0, make_bits(8'h55, 1'b0, 1'b0), 10, 1'b0, -1, "b55");
    idle_check(0, "b55");

    // 0x07 has three ones: even parity bit 1, odd parity bit 0.
    start_frame(1, 8'h07, 1'b0, 8'h00, 1'b0, "even");
    run_frame(1, make_bits(8'h07, 1'b1, 1'b1), 11, 1'b0, -1, "even");
    idle_check(1, "even");
    start_frame(2, 8'h07, 1'b0, 8'h00, 1'b0, "odd");
    run_frame(2, make_bits(8'h07, 1'b1, 1'b0), 11, 1'b0, -1, "odd");
    idle_check(2, "odd");

    // Two stop bits: 8 high cycles, done in the last one.
    start_frame(3, 8'hFF, 1'b0, 8'h00, 1'b0, "stop2");
    run_frame(3, make_bits(8'hFF, 1'b0, 1'b0), 11, 1'b0, -1, "stop2");
    idle_check(3, "stop2");

    // Back-to-back 0xA3 then 0x0F: second pop in the last stop cycle.
    start_frame(0, 8'hA3, 1'b1, 8'h0F, 1'b1, "b2b1");
    run_frame(0, make_bits(8'hA3, 1'b0, 1'b0), 10, 1'b1, -1, "b2b1");
    @(posedge clk);
    #1;
    dvalid = 1'b0;
    en[0]  = 1'b0;
    @(negedge clk);
    run_frame(0, make_bits(8'h0F, 1'b0, 1'b0), 10, 1'b0, -1, "b2b2");
    idle_check(0, "b2b2");

    // tx_en dropped during data bit 3 with FIFO still non-empty.
    start_frame(0, 8'h3C, 1'b1, 8'h99, 1'b1, "endrop");
    run_frame(0, make_bits(8'h3C, 1'b0, 1'b0), 10, 1'b0, 17, "endrop");
    repeat (6) begin
      @(negedge clk);
      chk("endrop_hold_tx",   32'(tx_v[0]),   32'd1);
      chk("endrop_hold_busy", 32'(busy_v[0]), 32'd0);
      chk("endrop_hold_rden", 32'(rden_v[0]), 32'd0);
    end
    dvalid = 1'b0;
    @(negedge clk);

    // Reset during data bit 5 of 0x81 (bit 5 = 0), FIFO ready throughout.
    start_frame(0, 8'h81, 1'b1, 8'h5A, 1'b1, "rstmid");
    repeat (25) @(negedge clk);
    chk("rstmid_bit5_tx", 32'(tx_v[0]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_tx",   32'(tx_v[0]),   32'd1);
    chk("rstmid_busy", 32'(busy_v[0]), 32'd0);
    chk("rstmid_done", 32'(done_v[0]), 32'd0);
    chk("rstmid_rden", 32'(rden_v[0]), 32'd0);
    @(negedge clk);
    chk("rstmid_rden2", 32'(rden_v[0]), 32'd0);
    rst = 1'b0;
    #1;
    chk("rstmid_restart_pop", 32'(rden_v[0]), 32'd1);
    @(posedge clk);
    #1;
    dvalid = 1'b0;
    en[0]  = 1'b0;
    @(negedge clk);
    run_frame(0, make_bits(8'h5A, 1'b0, 1'b0), 10, 1'b0, -1, "restart");
    idle_check(0, "restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
